// File: rtl/sle_pkg.sv
// Shared encodings for the SLE register-bank arbiter: FSM states and operation codes.
package sle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_SLOAD = 1'b1;

endpackage

// File: rtl/sle_reg_arbiter_if.sv
// Requester/bank bus of the SLE register arbiter; master = requester side, slave = arbiter.
interface sle_reg_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             REQ0;
  logic             OP0;
  logic [WIDTH-1:0] D0;
  logic             REQ1;
  logic             OP1;
  logic [WIDTH-1:0] D1;
  logic             GNT0;
  logic             GNT1;
  logic             ACK0;
  logic             ACK1;
  logic [WIDTH-1:0] Q;
  logic             BUSY;
  logic [CNT_W-1:0] XFER_CNT;

  modport master (
    output REQ0, OP0, D0, REQ1, OP1, D1,
    input  GNT0, GNT1, ACK0, ACK1, Q, BUSY, XFER_CNT
  );

  modport slave (
    input  REQ0, OP0, D0, REQ1, OP1, D1,
    output GNT0, GNT1, ACK0, ACK1, Q, BUSY, XFER_CNT
  );
endinterface

// File: rtl/sle_word.sv
// WIDTH-bit SLE-style register: async clear, enable, active-low synchronous load of SD_VAL.
module sle_word #(
  parameter int WIDTH  = 8,
  parameter bit SD_VAL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SLn,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_next[gi] = SLn ? D[gi] : SD_VAL;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= '0;
    end else if (EN) begin
      r_q <= w_next;
    end
  end

  assign Q = r_q;
endmodule

// File: rtl/sle_reg_arbiter.sv
// Two-requester arbiter sequencing writes/sync-loads into one shared SLE register bank.
// Macro SLE_ARB_ROUND_ROBIN_EN selects round-robin; undefined gives fixed priority to requester 0.
module sle_reg_arbiter
  import sle_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SD_VAL = 1'b0,
  parameter int CNT_W  = 8
) (
  input logic              CLK,
  input logic              RST,
  sle_reg_arbiter_if.slave bus
);
  state_t           r_state;
  logic             r_sel;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic             w_win;
  logic             w_op;
  logic             w_en;
  logic             w_sln;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_q;

`ifdef SLE_ARB_ROUND_ROBIN_EN
  logic r_last;
  // Contention goes to whoever did not win last; a lone request always wins.
  assign w_win = (bus.REQ0 && bus.REQ1) ? ~r_last : bus.REQ1;
`else
  assign w_win = ~bus.REQ0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
`ifdef SLE_ARB_ROUND_ROBIN_EN
      r_last  <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.REQ0 || bus.REQ1) begin
            r_sel   <= w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_busy  <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_ack0  <= ~r_sel;
          r_ack1  <= r_sel;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= ACK;
        end
        ACK: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
`ifdef SLE_ARB_ROUND_ROBIN_EN
          r_last  <= r_sel;
`endif
          r_state <= IDLE;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The bank only moves on the edge that ends XFER, using the winner's live inputs.
  assign w_en  = (r_state == XFER);
  assign w_op  = r_sel ? bus.OP1 : bus.OP0;
  assign w_sln = ~w_en | (w_op == OP_WRITE);
  assign w_d   = r_sel ? bus.D1 : bus.D0;

  sle_word #(
    .WIDTH (WIDTH),
    .SD_VAL(SD_VAL)
  ) u_word (
    .CLK(CLK),
    .RST(RST),
    .EN (w_en),
    .SLn(w_sln),
    .D  (w_d),
    .Q  (w_q)
  );

  assign bus.Q        = w_q;
  assign bus.GNT0     = r_gnt0;
  assign bus.GNT1     = r_gnt1;
  assign bus.ACK0     = r_ack0;
  assign bus.ACK1     = r_ack1;
  assign bus.BUSY     = r_busy;
  assign bus.XFER_CNT = r_cnt;
endmodule

// File: tb/tb_sle_reg_arbiter.sv
// Bench for sle_reg_arbiter: directed vector table, reset/drop sequences, randomized agents vs timeline model.
module tb_sle_reg_arbiter;
  import sle_pkg::*;

  localparam int WIDTH  = 8;
  localparam int CNT_W  = 2;
  localparam bit SD_VAL = 1'b0;
`ifdef SLE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  sle_reg_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  sle_reg_arbiter #(
    .WIDTH (WIDTH),
    .SD_VAL(SD_VAL),
    .CNT_W (CNT_W)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // {GNT0, GNT1, ACK0, ACK1, BUSY, Q, XFER_CNT}
  typedef logic [5+WIDTH+CNT_W-1:0] obs_t;

  typedef struct {
    logic       r0;
    logic       o0;
    logic [7:0] d0;
    logic       r1;
    logic       o1;
    logic [7:0] d1;
    obs_t       exp;
  } vec_t;

  vec_t tbl[21];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a transaction timeline (grant edge, completion edge, next allowed arbitration).
  int               e;
  int               g_edge;
  int               next_free;
  logic             m_sel;
  logic             m_last;
  logic [WIDTH-1:0] m_q;
  int               m_cnt;
  int               n_xfer;
  obs_t             m_exp;

  logic             a_req[2];
  logic             a_op[2];
  logic [7:0]       a_d[2];

  function automatic obs_t pack(logic g0, logic g1, logic a0, logic a1, logic b,
                                logic [WIDTH-1:0] q, logic [CNT_W-1:0] c);
    return {g0, g1, a0, a1, b, q, c};
  endfunction

  function automatic obs_t obs();
    return {bus.GNT0, bus.GNT1, bus.ACK0, bus.ACK1, bus.BUSY, bus.Q, bus.XFER_CNT};
  endfunction

  function automatic vec_t mk(logic r0, logic o0, logic [7:0] d0,
                              logic r1, logic o1, logic [7:0] d1, obs_t x);
    vec_t v;
    v.r0 = r0; v.o0 = o0; v.d0 = d0;
    v.r1 = r1; v.o1 = o1; v.d1 = d1;
    v.exp = x;
    return v;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic r0, logic o0, logic [7:0] d0, logic r1, logic o1, logic [7:0] d1);
    bus.REQ0 = r0; bus.OP0 = o0; bus.D0 = d0;
    bus.REQ1 = r1; bus.OP1 = o1; bus.D1 = d1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    e         = 0;
    g_edge    = -10;
    next_free = 0;
    m_sel     = 1'b0;
    m_last    = 1'b1;
    m_q       = '0;
    m_cnt     = 0;
  endtask

  task automatic model_step();
    logic             op;
    logic [WIDTH-1:0] d;
    e++;
    if (e == g_edge + 1) begin
      op     = m_sel ? bus.OP1 : bus.OP0;
      d      = m_sel ? bus.D1 : bus.D0;
      m_q    = (op == OP_SLOAD) ? {WIDTH{SD_VAL}} : d;
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      m_last = m_sel;
      n_xfer++;
      $display("xfer %0d: requester %0d op %0d q=%h cnt=%0d", n_xfer, m_sel, op, m_q, m_cnt);
    end
    if (e >= next_free && (bus.REQ0 || bus.REQ1)) begin
      if (bus.REQ0 && bus.REQ1) m_sel = RR ? ~m_last : 1'b0;
      else                      m_sel = bus.REQ1;
      g_edge    = e;
      next_free = e + 3;
    end
    m_exp = pack((e == g_edge) && !m_sel, (e == g_edge) && m_sel,
                 (e == g_edge + 1) && !m_sel, (e == g_edge + 1) && m_sel,
                 (e == g_edge) || (e == g_edge + 1), m_q, m_cnt[CNT_W-1:0]);
  endtask

  initial begin
    n_xfer = 0;
    for (int i = 0; i < 2; i++) begin
      a_req[i] = 1'b0; a_op[i] = 1'b0; a_d[i] = 8'h00;
    end

    // Single write, write FF then sync-load, then held contention (wraps the 2-bit counter).
    tbl[0]  = mk(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0));
    tbl[1]  = mk(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00, pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 2'd1));
    tbl[2]  = mk(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 2'd1));
    tbl[3]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 2'd1));
    tbl[4]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 2'd2));
    tbl[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 2'd2));
    tbl[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 2'd2));
    tbl[7]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 2'd3));
    tbl[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd3));
    tbl[9]  = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3));
    tbl[10] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2'd0));
    tbl[11] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 2'd0));
    tbl[12] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(!RR, RR, 1'b0, 1'b0, 1'b1, 8'h11, 2'd0));
    tbl[13] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(1'b0, 1'b0, !RR, RR, 1'b1, RR ? 8'h22 : 8'h11, 2'd1));
    tbl[14] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RR ? 8'h22 : 8'h11, 2'd1));
    tbl[15] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RR ? 8'h22 : 8'h11, 2'd1));
    tbl[16] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2'd2));
    tbl[17] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 2'd2));
    tbl[18] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(!RR, RR, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2));
    tbl[19] = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22, pack(1'b0, 1'b0, !RR, RR, 1'b1, RR ? 8'h22 : 8'h11, 2'd3));
    tbl[20] = mk(1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 8'h22, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RR ? 8'h22 : 8'h11, 2'd3));

    // Reset acts before any clock edge.
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    #2;
    check("reset_state", obs(), '0);
    do_reset();

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].r0, tbl[i].o0, tbl[i].d0, tbl[i].r1, tbl[i].o1, tbl[i].d1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Reset mid-XFER: everything clears at once and the aborted transfer never acks.
    drive(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("rst_pre_gnt", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RR ? 8'h22 : 8'h11, 2'd3));
    #2;
    rst = 1'b1;
    bus.REQ0 = 1'b0;
    #1;
    check("rst_async", obs(), '0);
    @(posedge clk);
    #1;
    check("rst_hold", obs(), '0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_no_ack%0d", i), obs(), '0);
    end

    // REQ dropped during XFER: transfer still completes with the data present at the edge.
    drive(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("drop_gnt", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0));
    bus.REQ0 = 1'b0;
    @(posedge clk);
    #1;
    check("drop_ack", obs(), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3, 2'd1));
    @(posedge clk);
    #1;
    check("drop_idle", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 2'd1));

    // Randomized protocol-following agents against the timeline model.
    do_reset();
    for (int cyc = 0; cyc < 450; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (a_req[i] && ((i == 0) ? bus.ACK0 : bus.ACK1)) begin
          if ($urandom_range(3) == 0) begin
            a_op[i] = 1'($urandom_range(1));
            a_d[i]  = 8'($urandom);
          end else begin
            a_req[i] = 1'b0;
          end
        end else if (!a_req[i] && $urandom_range(2) == 0) begin
          a_req[i] = 1'b1;
          a_op[i]  = 1'($urandom_range(1));
          a_d[i]   = 8'($urandom);
        end
      end
      drive(a_req[0], a_op[0], a_d[0], a_req[1], a_op[1], a_d[1]);
      @(posedge clk);
      #1;
      model_step();
      check($sformatf("rand%0d", cyc), obs(), m_exp);
      check("one_gnt", obs_t'(bus.GNT0 & bus.GNT1), '0);
      check("gnt_ack_excl", obs_t'((bus.GNT0 | bus.GNT1) & (bus.ACK0 | bus.ACK1)), '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
